// File: rtl/device_axi_bridge.sv
// Single-outstanding bridge from the core's uncached device port to an AXI4-Lite master.
// Optional posted writes with a one-entry pending request: define DEVICE_POSTED_WRITE_EN.
module device_axi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    dev_strobe_i,
  input  logic [ADDR_WIDTH-1:0]   dev_addr_i,
  input  logic                    dev_rw_i,
  input  logic [DATA_WIDTH/8-1:0] dev_byte_enable_i,
  input  logic [DATA_WIDTH-1:0]   dev_data_i,
  output logic                    dev_data_ready_o,
  output logic [DATA_WIDTH-1:0]   dev_data_o,
  output logic                    dev_resp_err_o,
`ifdef DEVICE_POSTED_WRITE_EN
  output logic                    posted_err_o,
`endif
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [STRB_W-1:0]     req_be;
  logic [DATA_WIDTH-1:0] req_data;

  logic                  wr_hs_done;
  logic                  b_hs;
  logic                  strobe_launch;
  logic                  launch_vld;
  logic                  launch_rw;
  logic [ADDR_WIDTH-1:0] launch_addr;
  logic [STRB_W-1:0]     launch_be;
  logic [DATA_WIDTH-1:0] launch_data;

  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    return a & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
  endfunction

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != 2'b00;
  endfunction

  // AXI payloads come straight from the request register, so they stay stable while valid.
  assign m_axi_awaddr = req_addr;
  assign m_axi_araddr = req_addr;
  assign m_axi_wdata  = req_data;
  assign m_axi_wstrb  = req_be;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  assign wr_hs_done = (state == WR_ADDR_DATA) &&
                      (!m_axi_awvalid || m_axi_awready) &&
                      (!m_axi_wvalid  || m_axi_wready);
  assign b_hs       = (state == WR_RESP) && m_axi_bvalid;

`ifdef DEVICE_POSTED_WRITE_EN
  logic                  pend_vld;
  logic                  pend_rw;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [STRB_W-1:0]     pend_be;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                  launch_pend;
  logic                  pend_capture;
  logic                  ack_write;

  // A strobe landing on the B handshake with nothing pending starts immediately instead of queueing.
  assign launch_pend   = pend_vld && b_hs;
  assign strobe_launch = dev_strobe_i && ((state == IDLE) || (b_hs && !pend_vld));
  assign pend_capture  = dev_strobe_i && !pend_vld &&
                         ((state == WR_ADDR_DATA) || ((state == WR_RESP) && !m_axi_bvalid));
  assign ack_write     = dev_rw_i && (strobe_launch || pend_capture);
`else
  assign strobe_launch = dev_strobe_i && (state == IDLE);
`endif

  always_comb begin
    launch_vld  = strobe_launch;
    launch_rw   = dev_rw_i;
    launch_addr = word_align(dev_addr_i);
    launch_be   = dev_byte_enable_i;
    launch_data = dev_data_i;
`ifdef DEVICE_POSTED_WRITE_EN
    if (launch_pend) begin
      launch_vld  = 1'b1;
      launch_rw   = pend_rw;
      launch_addr = pend_addr;
      launch_be   = pend_be;
      launch_data = pend_data;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state            <= IDLE;
      req_addr         <= '0;
      req_be           <= '0;
      req_data         <= '0;
      m_axi_awvalid    <= 1'b0;
      m_axi_wvalid     <= 1'b0;
      m_axi_bready     <= 1'b0;
      m_axi_arvalid    <= 1'b0;
      m_axi_rready     <= 1'b0;
      dev_data_ready_o <= 1'b0;
      dev_resp_err_o   <= 1'b0;
      dev_data_o       <= '0;
`ifdef DEVICE_POSTED_WRITE_EN
      posted_err_o     <= 1'b0;
      pend_vld         <= 1'b0;
      pend_rw          <= 1'b0;
      pend_addr        <= '0;
      pend_be          <= '0;
      pend_data        <= '0;
`endif
    end else begin
      dev_data_ready_o <= 1'b0;
      dev_resp_err_o   <= 1'b0;

      case (state)
        WR_ADDR_DATA: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (wr_hs_done) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            state        <= IDLE;
`ifdef DEVICE_POSTED_WRITE_EN
            if (resp_is_err(m_axi_bresp)) posted_err_o <= 1'b1;
`else
            dev_data_ready_o <= 1'b1;
            dev_resp_err_o   <= resp_is_err(m_axi_bresp);
`endif
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready     <= 1'b0;
            dev_data_o       <= m_axi_rdata;
            dev_data_ready_o <= 1'b1;
            dev_resp_err_o   <= resp_is_err(m_axi_rresp);
            state            <= IDLE;
          end
        end
        default: ;
      endcase

      // A launch overrides the return to IDLE taken above on the same edge.
      if (launch_vld) begin
        req_addr <= launch_addr;
        req_be   <= launch_be;
        req_data <= launch_data;
        if (launch_rw) begin
          m_axi_awvalid <= 1'b1;
          m_axi_wvalid  <= 1'b1;
          state         <= WR_ADDR_DATA;
        end else begin
          m_axi_arvalid <= 1'b1;
          state         <= RD_ADDR;
        end
      end

`ifdef DEVICE_POSTED_WRITE_EN
      if (pend_capture) begin
        pend_vld  <= 1'b1;
        pend_rw   <= dev_rw_i;
        pend_addr <= word_align(dev_addr_i);
        pend_be   <= dev_byte_enable_i;
        pend_data <= dev_data_i;
      end
      if (launch_pend) pend_vld <= 1'b0;
      if (ack_write) dev_data_ready_o <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_device_axi_bridge.sv
// Scoreboard bench for device_axi_bridge: a responsive AXI4-Lite slave model plus directed vectors.
module tb_device_axi_bridge;

`ifdef DEVICE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        dev_strobe;
  logic        dev_rw;
  logic [31:0] dev_addr;
  logic [3:0]  dev_be;
  logic [31:0] dev_data;
  logic        dev_data_ready;
  logic [31:0] dev_rdata;
  logic        dev_resp_err;
`ifdef DEVICE_POSTED_WRITE_EN
  logic        posted_err;
`endif
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  // slave model knobs, written only by the stimulus process
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = 32'h0;

  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_got, w_got, ar_got;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign bvalid  = aw_got && w_got && (b_cnt >= b_dly);
  assign rvalid  = ar_got && (r_cnt >= r_dly);
  assign bresp   = s_bresp;
  assign rresp   = s_rresp;
  assign rdata   = s_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) aw_got <= 1'b1;
      if (wvalid && wready) w_got <= 1'b1;
      if (bvalid && bready) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
      end else if (aw_got && w_got) b_cnt <= b_cnt + 1;
      if (arvalid && arready) ar_got <= 1'b1;
      if (rvalid && rready) begin
        ar_got <= 1'b0; r_cnt <= 0;
      end else if (ar_got) r_cnt <= r_cnt + 1;
    end
  end

  device_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .dev_strobe_i(dev_strobe), .dev_addr_i(dev_addr), .dev_rw_i(dev_rw),
    .dev_byte_enable_i(dev_be), .dev_data_i(dev_data),
    .dev_data_ready_o(dev_data_ready), .dev_data_o(dev_rdata), .dev_resp_err_o(dev_resp_err),
`ifdef DEVICE_POSTED_WRITE_EN
    .posted_err_o(posted_err),
`endif
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } done_t;

  done_t       done_q[$];
  logic [31:0] ar_q[$];
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int aw_hi  = 0;
  int w_hi   = 0;

  always_ff @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  function automatic void unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", nm);
  endfunction

  task automatic monitor();
    done_t d;
    forever begin
      @(negedge clk);
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (dev_data_ready) begin
        if (done_q.size() == 0) unexpected("ready_pulse");
        else begin
          d = done_q.pop_front();
          chk("ready_cycle", 64'(cyc), 64'(d.cyc));
          chk("dev_data", 64'(dev_rdata), 64'(d.data));
          chk("resp_err", 64'(dev_resp_err), 64'(d.err));
        end
      end else if (dev_resp_err) unexpected("err_without_ready");
      if (arvalid && arready) begin
        if (ar_q.size() == 0) unexpected("ar_handshake");
        else chk("araddr", 64'(araddr), 64'(ar_q.pop_front()));
      end
      if (awvalid && awready) begin
        if (aw_q.size() == 0) unexpected("aw_handshake");
        else chk("awaddr", 64'(awaddr), 64'(aw_q.pop_front()));
      end
      if (wvalid && wready) begin
        if (w_q.size() == 0) unexpected("w_handshake");
        else chk("wstrb_wdata", 64'({wstrb, wdata}), 64'(w_q.pop_front()));
      end
    end
  endtask

  // mode 0: strobe expected to be ignored; 1: full transaction; 2: AXI request only, no completion
  task automatic issue(input logic rw, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] data, input int lat, input logic [31:0] exp_data,
                       input logic exp_err, input int mode);
    done_t d;
    @(posedge clk); #1;
    dev_strobe = 1'b1; dev_rw = rw; dev_addr = addr; dev_be = be; dev_data = data;
    if (mode != 0) begin
      if (rw) begin
        aw_q.push_back(addr & 32'hFFFF_FFFC);
        w_q.push_back({be, data});
      end else ar_q.push_back(addr & 32'hFFFF_FFFC);
      if (mode == 1) begin
        d.data = exp_data;
        d.err  = (rw && POSTED) ? 1'b0 : exp_err;
        d.cyc  = cyc + ((rw && POSTED) ? 1 : lat);
        done_q.push_back(d);
      end
    end
    @(posedge clk); #1;
    dev_strobe = 1'b0; dev_rw = 1'b0; dev_addr = '0; dev_be = '0; dev_data = '0;
  endtask

  task automatic wait_done(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (done_q.size() == 0 && ar_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0 &&
          !aw_got && !w_got && !ar_got) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  initial begin
    int a0, w0;
    rst_n = 1'b0;
    dev_strobe = 1'b0; dev_rw = 1'b0; dev_addr = '0; dev_be = '0; dev_data = '0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk); #1;
    chk("reset_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, dev_data_ready, dev_resp_err}), 64'd0);
    chk("reset_addr", 64'({awaddr, araddr}), 64'd0);
    chk("reset_wr", 64'({wstrb, wdata}), 64'd0);
    chk("reset_rdata_prot", 64'({dev_rdata, awprot, arprot}), 64'd0);
`ifdef DEVICE_POSTED_WRITE_EN
    chk("reset_posted_err", 64'(posted_err), 64'd0);
`endif
    rst_n = 1'b1;

    // zero-wait read
    s_rdata = 32'h1234_5678;
    issue(1'b0, 32'hC000_0104, 4'h0, 32'h0, 3, 32'h1234_5678, 1'b0, 1);
    wait_done("done_read0");

    // zero-wait write, unaligned address and partial strobe; read data must be held
    issue(1'b1, 32'hC000_0203, 4'b0011, 32'hA5A5_A5A5, 3, 32'h1234_5678, 1'b0, 1);
    wait_done("done_write0");

    // same write, WREADY four cycles after AWREADY
    w_dly = 4;
    a0 = aw_hi; w0 = w_hi;
    issue(1'b1, 32'hC000_0203, 4'b0011, 32'hA5A5_A5A5, 7, 32'h1234_5678, 1'b0, 1);
    wait_done("done_write_wdly");
    chk("awvalid_cycles", 64'(aw_hi - a0), 64'd1);
    chk("wvalid_cycles", 64'(w_hi - w0), 64'd5);
    w_dly = 0;

    // SLVERR read still delivers its data
    s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b10;
    issue(1'b0, 32'hC000_0108, 4'h0, 32'h0, 3, 32'hDEAD_BEEF, 1'b1, 1);
    wait_done("done_read_err");
    s_rresp = 2'b00;

    // AR and R delays add cycles
    ar_dly = 2; r_dly = 3; s_rdata = 32'h0BAD_F00D;
    issue(1'b0, 32'hC0FF_FFFE, 4'h0, 32'h0, 8, 32'h0BAD_F00D, 1'b0, 1);
    wait_done("done_read_dly");
    ar_dly = 0; r_dly = 0;

    // DECERR write response with B delay
    s_bresp = 2'b11; b_dly = 2;
    issue(1'b1, 32'hC000_0010, 4'b1000, 32'h0102_0304, 5, 32'h0BAD_F00D, 1'b1, 1);
    wait_done("done_write_err");
    s_bresp = 2'b00; b_dly = 0;

    // strobe during a read in flight is ignored
    r_dly = 5; s_rdata = 32'h55AA_55AA;
    issue(1'b0, 32'hC000_0020, 4'h0, 32'h0, 8, 32'h55AA_55AA, 1'b0, 1);
    issue(1'b1, 32'hC000_0024, 4'hF, 32'hFFFF_FFFF, 0, 32'h0, 1'b0, 0);
    wait_done("done_ignored");
    r_dly = 0;

    // back-to-back reads: second strobe in the cycle after the first pulse
    s_rdata = 32'h1111_1111;
    issue(1'b0, 32'hC000_0030, 4'h0, 32'h0, 3, 32'h1111_1111, 1'b0, 1);
    wait_done("done_b2b_0");
    s_rdata = 32'h2222_2222;
    issue(1'b0, 32'hC000_0034, 4'h0, 32'h0, 3, 32'h2222_2222, 1'b0, 1);
    wait_done("done_b2b_1");

    // reset while waiting for R: everything clears at once, no pulse
    r_dly = 10; s_rdata = 32'h7777_7777;
    issue(1'b0, 32'hC000_0400, 4'h0, 32'h0, 0, 32'h0, 1'b0, 2);
    @(posedge clk); #2;
    chk("rready_before_reset", 64'(rready), 64'd1);
    rst_n = 1'b0; #1;
    chk("reset_async_ctrl", 64'({arvalid, rready, awvalid, wvalid, bready, dev_data_ready, dev_resp_err}), 64'd0);
    chk("reset_async_rdata", 64'(dev_rdata), 64'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1; r_dly = 0;
    wait_done("drain_after_reset");

    s_rdata = 32'h3333_3333;
    issue(1'b0, 32'hC000_0040, 4'h0, 32'h0, 3, 32'h3333_3333, 1'b0, 1);
    wait_done("done_read_after_reset");

`ifdef DEVICE_POSTED_WRITE_EN
    // posted write, read queued behind it, SLVERR on B
    chk("posted_err_clear", 64'(posted_err), 64'd0);
    b_dly = 5; s_bresp = 2'b10; s_rdata = 32'h4444_4444;
    issue(1'b1, 32'hC000_0300, 4'hF, 32'hCAFE_F00D, 1, 32'h3333_3333, 1'b0, 1);
    issue(1'b0, 32'hC000_0304, 4'h0, 32'h0, 8, 32'h4444_4444, 1'b0, 1);
    wait_done("done_posted");
    chk("posted_err_set", 64'(posted_err), 64'd1);
    b_dly = 0; s_bresp = 2'b00;
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
